// File: rtl/axi4_mp_mem.sv
// Multiport AXI4 slave memory: PORTS_AMOUNT independent AXI4 slave ports over one shared word array.
// Storage starts all-zero.
module axi4_mp_mem #(
  parameter int unsigned           PORTS_AMOUNT   = 2,
  parameter int unsigned           DATA_WIDTH     = 64,
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter int unsigned           ID_WIDTH       = 1,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'h3fff_0000,
  parameter int unsigned           MEM_WORDS_LOG2 = 20,
  parameter string                 INIT_FILE      = "mem_init.hex"
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic [PORTS_AMOUNT-1:0][ID_WIDTH-1:0]     awid,
  input  logic [PORTS_AMOUNT-1:0][ADDR_WIDTH-1:0]   awaddr,
  input  logic [PORTS_AMOUNT-1:0][7:0]              awlen,
  input  logic [PORTS_AMOUNT-1:0][2:0]              awsize,
  input  logic [PORTS_AMOUNT-1:0][1:0]              awburst,
  input  logic [PORTS_AMOUNT-1:0]                   awvalid,
  output logic [PORTS_AMOUNT-1:0]                   awready,
  input  logic [PORTS_AMOUNT-1:0][DATA_WIDTH-1:0]   wdata,
  input  logic [PORTS_AMOUNT-1:0][DATA_WIDTH/8-1:0] wstrb,
  input  logic [PORTS_AMOUNT-1:0]                   wlast,
  input  logic [PORTS_AMOUNT-1:0]                   wvalid,
  output logic [PORTS_AMOUNT-1:0]                   wready,
  output logic [PORTS_AMOUNT-1:0][ID_WIDTH-1:0]     bid,
  output logic [PORTS_AMOUNT-1:0][1:0]              bresp,
  output logic [PORTS_AMOUNT-1:0]                   bvalid,
  input  logic [PORTS_AMOUNT-1:0]                   bready,
  input  logic [PORTS_AMOUNT-1:0][ID_WIDTH-1:0]     arid,
  input  logic [PORTS_AMOUNT-1:0][ADDR_WIDTH-1:0]   araddr,
  input  logic [PORTS_AMOUNT-1:0][7:0]              arlen,
  input  logic [PORTS_AMOUNT-1:0][2:0]              arsize,
  input  logic [PORTS_AMOUNT-1:0][1:0]              arburst,
  input  logic [PORTS_AMOUNT-1:0]                   arvalid,
  output logic [PORTS_AMOUNT-1:0]                   arready,
  output logic [PORTS_AMOUNT-1:0][ID_WIDTH-1:0]     rid,
  output logic [PORTS_AMOUNT-1:0][DATA_WIDTH-1:0]   rdata,
  output logic [PORTS_AMOUNT-1:0][1:0]              rresp,
  output logic [PORTS_AMOUNT-1:0]                   rlast,
  output logic [PORTS_AMOUNT-1:0]                   rvalid,
  input  logic [PORTS_AMOUNT-1:0]                   rready
);

  localparam int unsigned           StrbWidth = DATA_WIDTH / 8;
  localparam int unsigned           WordShift = $clog2(StrbWidth);
  localparam int unsigned           Depth     = 2 ** MEM_WORDS_LOG2;
  localparam logic [ADDR_WIDTH-1:0] WordBytes = ADDR_WIDTH'(StrbWidth);

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstWrap  = 2'b10;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] RespDecerr = 2'b11;

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic {RIdle, RData} r_state_e;

  // Beat size is always the full bus width, so the size fields carry no information.
  logic unused_size;
  logic unused_init;
  assign unused_size = ^{awsize, arsize};
  assign unused_init = (INIT_FILE == "");

  logic [DATA_WIDTH-1:0] mem [Depth] = '{default: '0};

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - BASE_ADDR;
    return (addr >= BASE_ADDR) && ((off >> (WordShift + MEM_WORDS_LOG2)) == '0);
  endfunction

  function automatic logic [MEM_WORDS_LOG2-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] addr);
    return MEM_WORDS_LOG2'((addr - BASE_ADDR) >> WordShift);
  endfunction

  logic [PORTS_AMOUNT-1:0]                     mem_we;
  logic [PORTS_AMOUNT-1:0][MEM_WORDS_LOG2-1:0] mem_widx;

  // Ports are applied in ascending order so the highest index wins each byte.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < PORTS_AMOUNT; p++) begin
      if (mem_we[p]) begin
        for (int b = 0; b < StrbWidth; b++) begin
          if (wstrb[p][b]) mem[mem_widx[p]][b*8 +: 8] <= wdata[p][b*8 +: 8];
        end
      end
    end
  end

  for (genvar p = 0; p < PORTS_AMOUNT; p++) begin : g_port
    // Write path
    w_state_e              w_state_q, w_state_d;
    logic [ID_WIDTH-1:0]   w_id_q, w_id_d;
    logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [7:0]            w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic                  w_fixed_q, w_fixed_d;
    logic                  w_slverr_q, w_slverr_d, w_decerr_q, w_decerr_d;
    logic                  w_we, w_final;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        w_state_q  <= WIdle;
        w_id_q     <= '0;
        w_addr_q   <= '0;
        w_len_q    <= '0;
        w_cnt_q    <= '0;
        w_fixed_q  <= 1'b0;
        w_slverr_q <= 1'b0;
        w_decerr_q <= 1'b0;
      end else begin
        w_state_q  <= w_state_d;
        w_id_q     <= w_id_d;
        w_addr_q   <= w_addr_d;
        w_len_q    <= w_len_d;
        w_cnt_q    <= w_cnt_d;
        w_fixed_q  <= w_fixed_d;
        w_slverr_q <= w_slverr_d;
        w_decerr_q <= w_decerr_d;
      end
    end

    always_comb begin
      w_state_d  = w_state_q;
      w_id_d     = w_id_q;
      w_addr_d   = w_addr_q;
      w_len_d    = w_len_q;
      w_cnt_d    = w_cnt_q;
      w_fixed_d  = w_fixed_q;
      w_slverr_d = w_slverr_q;
      w_decerr_d = w_decerr_q;
      w_we       = 1'b0;
      w_final    = (w_cnt_q == w_len_q);
      awready[p] = 1'b0;
      wready[p]  = 1'b0;
      bvalid[p]  = 1'b0;
      bid[p]     = w_id_q;
      bresp[p]   = w_decerr_q ? RespDecerr : (w_slverr_q ? RespSlverr : RespOkay);
      unique case (w_state_q)
        WIdle: begin
          awready[p] = !rst_i;
          if (awvalid[p] && !rst_i) begin
            w_state_d  = WData;
            w_id_d     = awid[p];
            w_addr_d   = awaddr[p];
            w_len_d    = awlen[p];
            w_cnt_d    = 8'd0;
            w_fixed_d  = (awburst[p] == BurstFixed);
            w_slverr_d = (awburst[p] == BurstWrap);
            w_decerr_d = 1'b0;
          end
        end
        WData: begin
          wready[p] = !rst_i;
          if (wvalid[p] && !rst_i) begin
            w_we       = addr_ok(w_addr_q);
            w_decerr_d = w_decerr_q | ~addr_ok(w_addr_q);
            w_cnt_d    = w_cnt_q + 8'd1;
            w_addr_d   = w_fixed_q ? w_addr_q : w_addr_q + WordBytes;
            // wlast must coincide with the awlen-th beat; either mismatch is a slave error.
            if (wlast[p] != w_final) w_slverr_d = 1'b1;
            if (wlast[p] || w_final) w_state_d = WResp;
          end
        end
        WResp: begin
          bvalid[p] = !rst_i;
          if (bready[p] && !rst_i) w_state_d = WIdle;
        end
        default: w_state_d = WIdle;
      endcase
    end

    assign mem_we[p]   = w_we;
    assign mem_widx[p] = addr_idx(w_addr_q);

    // Read path; r_addr_q is the address of the next beat to fetch.
    r_state_e              r_state_q, r_state_d;
    logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
    logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d, r_fetch_addr;
    logic [7:0]            r_len_q, r_len_d, r_cnt_q, r_cnt_d;
    logic                  r_fixed_q, r_fixed_d, r_wrap_q, r_wrap_d;
    logic                  r_fetch, r_fetch_wrap;
    logic [DATA_WIDTH-1:0] r_data_q;
    logic [1:0]            r_resp_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_state_q <= RIdle;
        r_id_q    <= '0;
        r_addr_q  <= '0;
        r_len_q   <= '0;
        r_cnt_q   <= '0;
        r_fixed_q <= 1'b0;
        r_wrap_q  <= 1'b0;
      end else begin
        r_state_q <= r_state_d;
        r_id_q    <= r_id_d;
        r_addr_q  <= r_addr_d;
        r_len_q   <= r_len_d;
        r_cnt_q   <= r_cnt_d;
        r_fixed_q <= r_fixed_d;
        r_wrap_q  <= r_wrap_d;
      end
    end

    always_comb begin
      r_state_d    = r_state_q;
      r_id_d       = r_id_q;
      r_addr_d     = r_addr_q;
      r_len_d      = r_len_q;
      r_cnt_d      = r_cnt_q;
      r_fixed_d    = r_fixed_q;
      r_wrap_d     = r_wrap_q;
      r_fetch      = 1'b0;
      r_fetch_addr = r_addr_q;
      r_fetch_wrap = r_wrap_q;
      arready[p]   = 1'b0;
      rvalid[p]    = 1'b0;
      unique case (r_state_q)
        RIdle: begin
          arready[p] = !rst_i;
          if (arvalid[p] && !rst_i) begin
            r_state_d    = RData;
            r_id_d       = arid[p];
            r_len_d      = arlen[p];
            r_cnt_d      = 8'd0;
            r_fixed_d    = (arburst[p] == BurstFixed);
            r_wrap_d     = (arburst[p] == BurstWrap);
            r_fetch      = 1'b1;
            r_fetch_addr = araddr[p];
            r_fetch_wrap = (arburst[p] == BurstWrap);
            r_addr_d     = (arburst[p] == BurstFixed) ? araddr[p] : araddr[p] + WordBytes;
          end
        end
        RData: begin
          rvalid[p] = !rst_i;
          if (rready[p] && !rst_i) begin
            if (r_cnt_q == r_len_q) begin
              r_state_d = RIdle;
            end else begin
              r_cnt_d  = r_cnt_q + 8'd1;
              r_fetch  = 1'b1;
              r_addr_d = r_fixed_q ? r_addr_q : r_addr_q + WordBytes;
            end
          end
        end
        default: r_state_d = RIdle;
      endcase
      rlast[p] = rvalid[p] && (r_cnt_q == r_len_q);
      rid[p]   = r_id_q;
      rdata[p] = r_data_q;
      rresp[p] = r_resp_q;
    end

    // Registered fetch: a same-cycle write to the word lands after this read, giving old data.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_data_q <= '0;
        r_resp_q <= RespOkay;
      end else if (r_fetch) begin
        r_data_q <= addr_ok(r_fetch_addr) ? mem[addr_idx(r_fetch_addr)] : '0;
        r_resp_q <= !addr_ok(r_fetch_addr) ? RespDecerr : (r_fetch_wrap ? RespSlverr : RespOkay);
      end
    end
  end

endmodule

// File: tb/tb_axi4_mp_mem.sv
// Randomized self-checking bench for axi4_mp_mem against an array-based memory model.
module tb_axi4_mp_mem;

  localparam int          P        = 2;
  localparam int          DW       = 64;
  localparam int          AW       = 32;
  localparam int          IDW      = 1;
  localparam int          MEM_LOG2 = 10;
  localparam int          DEPTH    = 1 << MEM_LOG2;
  localparam logic [31:0] BASE     = 32'h3fff_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [P-1:0][IDW-1:0] awid, bid, arid, rid;
  logic [P-1:0][AW-1:0]  awaddr, araddr;
  logic [P-1:0][7:0]     awlen, arlen;
  logic [P-1:0][2:0]     awsize, arsize;
  logic [P-1:0][1:0]     awburst, arburst, bresp, rresp;
  logic [P-1:0][DW-1:0]  wdata, rdata;
  logic [P-1:0][7:0]     wstrb;
  logic [P-1:0]          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [P-1:0]          arvalid, arready, rlast, rvalid, rready;

  axi4_mp_mem #(
    .PORTS_AMOUNT(P), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IDW),
    .BASE_ADDR(BASE), .MEM_WORDS_LOG2(MEM_LOG2), .INIT_FILE("mem_init.hex")
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] model [DEPTH];
  logic [63:0] wbuf [P][256];
  logic [7:0]  sbuf [P][256];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    longint off;
    off = longint'(a) - longint'(BASE);
    return (off >= 0) && (off / 8 < DEPTH);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((longint'(a) - longint'(BASE)) / 8);
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] burst,
                                            input int i);
    return (burst == 2'b00) ? a : a + 32'(i * 8);
  endfunction

  function automatic logic [1:0] exp_bresp(input logic [31:0] a, input int len,
                                           input logic [1:0] burst, input int nbeats,
                                           input bit last_flag);
    bit dec = 1'b0;
    for (int i = 0; i < nbeats; i++) if (!in_rng(beat_addr(a, burst, i))) dec = 1'b1;
    if (dec) return 2'b11;
    if (burst == 2'b10 || nbeats != len + 1 || !last_flag) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_write(input int p, input logic [31:0] a, input logic [1:0] burst,
                             input int nbeats);
    logic [31:0] ba;
    for (int i = 0; i < nbeats; i++) begin
      ba = beat_addr(a, burst, i);
      if (in_rng(ba))
        for (int b = 0; b < 8; b++)
          if (sbuf[p][i][b]) model[widx(ba)][b*8 +: 8] = wbuf[p][i][b*8 +: 8];
    end
  endtask

  function automatic logic sel(input int p, input int which);
    case (which)
      0:       return awready[p];
      1:       return wready[p];
      2:       return bvalid[p];
      default: return arready[p];
    endcase
  endfunction

  // Returns on the falling edge where the selected signal is high, or after a bounded wait.
  task automatic wait_hi(input int p, input int which, input string tag);
    int cyc = 0;
    forever begin
      @(negedge clk);
      if (sel(p, which)) break;
      cyc++;
      if (cyc > 100) begin
        check_eq({tag, "_timeout"}, 64'(sel(p, which)), 64'd1);
        break;
      end
    end
  endtask

  task automatic fill(input int p, input int n, input bit full);
    for (int i = 0; i < n; i++) begin
      wbuf[p][i] = {$urandom, $urandom};
      sbuf[p][i] = full ? 8'hff : 8'($urandom);
    end
  endtask

  task automatic axi_write(input int p, input logic [31:0] a, input int len,
                           input logic [1:0] burst, input int nbeats, input bit last_flag);
    logic [IDW-1:0] id;
    id = IDW'($urandom);
    awid[p] = id; awaddr[p] = a; awlen[p] = 8'(len); awburst[p] = burst;
    awsize[p] = 3'd3; awvalid[p] = 1'b1;
    wait_hi(p, 0, "aw");
    @(posedge clk); #1;
    awvalid[p] = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      wdata[p] = wbuf[p][i]; wstrb[p] = sbuf[p][i];
      wlast[p] = last_flag && (i == nbeats - 1); wvalid[p] = 1'b1;
      wait_hi(p, 1, "w");
      @(posedge clk); #1;
    end
    wvalid[p] = 1'b0; wlast[p] = 1'b0; bready[p] = 1'b1;
    wait_hi(p, 2, "b");
    check_eq("bresp", 64'(bresp[p]), 64'(exp_bresp(a, len, burst, nbeats, last_flag)));
    check_eq("bid", 64'(bid[p]), 64'(id));
    @(posedge clk); #1;
    bready[p] = 1'b0;
  endtask

  function automatic logic rr_pat(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return 1'($urandom);
      default: return (c % 4 == 0) || (c % 4 == 3);
    endcase
  endfunction

  task automatic axi_read(input int p, input logic [31:0] a, input int len,
                          input logic [1:0] burst, input int mode);
    logic [IDW-1:0] id;
    logic [31:0]    ba;
    logic [63:0]    hd;
    bit             held, ok;
    int             beat, cyc;
    id = IDW'($urandom);
    arid[p] = id; araddr[p] = a; arlen[p] = 8'(len); arburst[p] = burst;
    arsize[p] = 3'd3; arvalid[p] = 1'b1;
    wait_hi(p, 3, "ar");
    @(posedge clk); #1;
    arvalid[p] = 1'b0;
    rready[p] = rr_pat(mode, 0);
    @(negedge clk);
    check_eq("rvalid_first", 64'(rvalid[p]), 64'd1);
    beat = 0; cyc = 0; held = 1'b0; hd = '0;
    forever begin
      if (rvalid[p]) begin
        if (held) check_eq("r_stable", rdata[p], hd);
        if (rready[p]) begin
          ba = beat_addr(a, burst, beat);
          ok = in_rng(ba);
          check_eq("rdata", rdata[p], ok ? model[widx(ba)] : 64'd0);
          check_eq("rresp", 64'(rresp[p]), !ok ? 64'd3 : (burst == 2'b10 ? 64'd2 : 64'd0));
          check_eq("rlast", 64'(rlast[p]), 64'(beat == len));
          check_eq("rid", 64'(rid[p]), 64'(id));
          beat++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          hd   = rdata[p];
        end
      end
      if (beat > len) break;
      cyc++;
      if (cyc > 300) begin
        check_eq("r_timeout", 64'(beat), 64'(len + 1));
        break;
      end
      @(posedge clk); #1;
      rready[p] = rr_pat(mode, cyc);
      @(negedge clk);
    end
    @(posedge clk); #1;
    rready[p] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  burst;
    int          p, len, woff, nb, sel_op;
    bit          lf;

    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = '0;
    wdata = '0; wstrb = '0; wlast = '0; wvalid = '0; bready = '0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = '0; rready = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_awready", 64'(awready), 64'd0);
    check_eq("rst_arready", 64'(arready), 64'd0);
    check_eq("rst_bvalid", 64'(bvalid), 64'd0);
    check_eq("rst_rvalid", 64'(rvalid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("awready_after_rst", 64'(awready), 64'd3);
    check_eq("arready_after_rst", 64'(arready), 64'd3);
    @(posedge clk); #1;

    // Frame-buffer style: port 0 writes, port 1 reads back at full throughput.
    for (int i = 0; i < 4; i++) begin
      wbuf[0][i] = 64'h1111_1111_1111_1111 * 64'(i + 1);
      sbuf[0][i] = 8'hff;
    end
    axi_write(0, BASE, 3, 2'b01, 4, 1'b1);
    model_write(0, BASE, 2'b01, 4);
    axi_read(1, BASE, 3, 2'b01, 0);

    // Byte strobes merge into the existing word.
    wbuf[0][0] = 64'hffff_ffff_ffff_ffff; sbuf[0][0] = 8'hff;
    axi_write(0, BASE + 32'h100, 0, 2'b01, 1, 1'b1);
    model_write(0, BASE + 32'h100, 2'b01, 1);
    wbuf[0][0] = 64'h0; sbuf[0][0] = 8'h0f;
    axi_write(0, BASE + 32'h100, 0, 2'b01, 1, 1'b1);
    model_write(0, BASE + 32'h100, 2'b01, 1);
    axi_read(1, BASE + 32'h100, 0, 2'b01, 0);

    // Range boundaries: below base, past the top, and a burst climbing into range.
    axi_read(0, 32'h3ffe_fff8, 0, 2'b01, 0);
    fill(1, 1, 1'b1);
    axi_write(1, BASE + 32'(DEPTH * 8), 0, 2'b01, 1, 1'b1);
    model_write(1, BASE + 32'(DEPTH * 8), 2'b01, 1);
    axi_read(1, BASE + 32'(DEPTH * 8), 0, 2'b01, 0);
    axi_read(0, BASE - 32'd16, 3, 2'b01, 0);
    axi_read(1, BASE + 32'((DEPTH - 2) * 8), 3, 2'b01, 0);

    // Protocol errors: WRAP, early wlast, missing wlast; FIXED burst.
    fill(0, 8, 1'b0);
    axi_write(0, BASE + 32'h200, 3, 2'b10, 4, 1'b1);
    model_write(0, BASE + 32'h200, 2'b10, 4);
    axi_read(0, BASE + 32'h200, 3, 2'b10, 0);
    fill(0, 8, 1'b1);
    axi_write(0, BASE + 32'h240, 5, 2'b01, 2, 1'b1);
    model_write(0, BASE + 32'h240, 2'b01, 2);
    fill(0, 8, 1'b1);
    axi_write(0, BASE + 32'h280, 2, 2'b01, 3, 1'b0);
    model_write(0, BASE + 32'h280, 2'b01, 3);
    fill(1, 4, 1'b0);
    axi_write(1, BASE + 32'h2c0, 3, 2'b00, 4, 1'b1);
    model_write(1, BASE + 32'h2c0, 2'b00, 4);
    axi_read(0, BASE + 32'h240, 15, 2'b01, 1);
    axi_read(1, BASE + 32'h2c0, 2, 2'b00, 0);

    // Backpressure 1,0,0,1 across an 8-beat read.
    fill(0, 8, 1'b1);
    axi_write(0, BASE + 32'h300, 7, 2'b01, 8, 1'b1);
    model_write(0, BASE + 32'h300, 2'b01, 8);
    axi_read(1, BASE + 32'h300, 7, 2'b01, 2);

    // Same-cycle writes from both ports: port 1 wins every byte it strobes.
    for (int k = 0; k < 2; k++) begin
      wbuf[0][0] = 64'haa; sbuf[0][0] = 8'hff;
      wbuf[1][0] = 64'hbb; sbuf[1][0] = (k == 0) ? 8'hff : 8'h0e;
      wbuf[0][0] = (k == 0) ? 64'haa : 64'haaaa_aaaa_aaaa_aaaa;
      wbuf[1][0] = (k == 0) ? 64'hbb : 64'hbbbb_bbbb_bbbb_bbbb;
      fork
        axi_write(0, BASE + 32'h400, 0, 2'b01, 1, 1'b1);
        axi_write(1, BASE + 32'h400, 0, 2'b01, 1, 1'b1);
      join
      model_write(0, BASE + 32'h400, 2'b01, 1);
      model_write(1, BASE + 32'h400, 2'b01, 1);
      axi_read(0, BASE + 32'h400, 0, 2'b01, 0);
    end

    // Reset in the middle of a 16-beat write aborts it without a response.
    a = BASE + 32'h600;
    awaddr[0] = a; awlen[0] = 8'd15; awburst[0] = 2'b01; awsize[0] = 3'd3; awvalid[0] = 1'b1;
    wait_hi(0, 0, "aw_rst");
    @(posedge clk); #1;
    awvalid[0] = 1'b0;
    fill(0, 5, 1'b1);
    for (int i = 0; i < 5; i++) begin
      wdata[0] = wbuf[0][i]; wstrb[0] = sbuf[0][i]; wlast[0] = 1'b0; wvalid[0] = 1'b1;
      wait_hi(0, 1, "w_rst");
      @(posedge clk); #1;
    end
    model_write(0, a, 2'b01, 5);
    wvalid[0] = 1'b0; bready[0] = 1'b1; rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("mid_rst_awready", 64'(awready[0]), 64'd0);
      check_eq("mid_rst_bvalid", 64'(bvalid[0]), 64'd0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) check_eq("awready_post_rst", 64'(awready[0]), 64'd1);
      check_eq("no_bvalid_aborted", 64'(bvalid[0]), 64'd0);
      @(posedge clk); #1;
    end
    bready[0] = 1'b0;
    fill(0, 4, 1'b1);
    axi_write(0, a, 3, 2'b01, 4, 1'b1);
    model_write(0, a, 2'b01, 4);
    axi_read(1, a, 15, 2'b01, 1);

    // Random traffic, one transaction at a time.
    for (int k = 0; k < 80; k++) begin
      p     = int'($urandom % 2);
      len   = int'($urandom % 8);
      burst = 2'($urandom % 3);
      woff  = ($urandom % 4 == 0) ? DEPTH - 4 + int'($urandom % 8) : int'($urandom % 44) - 4;
      a     = BASE + 32'(woff * 8);
      if ($urandom % 2 == 0) begin
        sel_op = int'($urandom % 6);
        nb = len + 1; lf = 1'b1;
        if (sel_op == 0 && len > 0) nb = 1 + int'($urandom % len);
        if (sel_op == 1) lf = 1'b0;
        fill(p, nb, $urandom % 3 == 0);
        axi_write(p, a, len, burst, nb, lf);
        model_write(p, a, burst, nb);
      end else begin
        axi_read(p, a, len, burst, 1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
